iir_coef_loader: RTL and testbench
==================================

IIR_COEF_LOADER -- requirements
Module: iir_coef_loader

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the coefficient and write-data width in bits.
REQ-002 The block SHALL have parameter B0_RST, default 16'sh4000, meaning the active b0 value after reset (unity passthrough).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: the host offers a coefficient write.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write.
REQ-007 The block SHALL have port wr_addr, input, 3 bits: coefficient select; 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-008 The block SHALL have port wr_data, input, signed DW bits: the coefficient value.
REQ-009 The block SHALL have port commit, input, 1 bit: a one-cycle request to apply the shadow set.
REQ-010 The block SHALL have port abort, input, 1 bit: discard the pending load.
REQ-011 The block SHALL have port sample_tick, input, 1 bit: a one-cycle strobe marking a filter sample boundary.
REQ-012 The block SHALL have ports b0, b1, b2, a1, a2, output, signed DW bits each: the active coefficients that drive the IIR stage.
REQ-013 The block SHALL have port pending, output, 1 bit: high while a committed set waits for sample_tick.
REQ-014 The block SHALL have port applied, output, 1 bit: a one-cycle pulse when the active set changes.
REQ-015 The block SHALL have port err, output, 1 bit: a one-cycle pulse on an illegal address or an illegal commit.

Function
REQ-016 The block SHALL hold five shadow registers and five active registers; b0, b1, b2, a1 and a2 SHALL be driven only from the active registers.
REQ-017 The block SHALL track a 5-bit written-mask, one bit per shadow register.
REQ-018 The state machine SHALL have three states: IDLE (mask empty), LOAD (at least one bit of the mask set), and PEND (commit accepted).
REQ-019 wr_ready SHALL be 1 in IDLE and LOAD and 0 in PEND.
REQ-020 A write SHALL be accepted only when wr_valid and wr_ready are both 1.
REQ-021 An accepted write with wr_addr 0-4 SHALL update the selected shadow register and set its mask bit at the next edge; the state SHALL go IDLE->LOAD.
REQ-022 Rewriting the same address SHALL overwrite the shadow value, and the mask SHALL stay set.
REQ-023 An accepted write with wr_addr 5-7 SHALL be dropped, SHALL leave the shadow and mask unchanged, and SHALL pulse err at the next edge.
REQ-024 commit SHALL be evaluated against the mask including any write accepted in the same cycle.
REQ-025 commit with the full mask (5'b11111) in LOAD SHALL move the state to PEND, with pending=1 from the next cycle.
REQ-026 commit with an incomplete mask, or in IDLE, SHALL pulse err and leave the state unchanged.
REQ-027 commit in PEND SHALL be ignored.
REQ-028 In PEND, on sample_tick=1 all five active registers SHALL load from the shadow at that edge, atomically; applied SHALL pulse for 1 cycle, the mask SHALL clear, the state SHALL go to IDLE, and pending SHALL drop.
REQ-029 New coefficients SHALL be visible on the outputs 1 cycle after the sample_tick cycle.
REQ-030 A sample_tick in IDLE or LOAD SHALL have no effect.
REQ-031 A sample_tick in the same cycle as an accepted commit SHALL NOT apply the set; the block SHALL wait for the next tick.
REQ-032 abort in LOAD or PEND SHALL clear the mask, SHALL return to IDLE at the next edge, SHALL leave the active set unchanged, and SHALL keep the shadow values.
REQ-033 abort SHALL take priority over commit, sample_tick and write-mask updates in the same cycle.
REQ-034 The active set SHALL never change except through REQ-028 or reset.
REQ-035 Outputs SHALL be registered, with no combinational path from inputs to b0, b1, b2, a1 or a2.

Reset
REQ-036 On reset=1 at an edge, the state SHALL go to IDLE and the mask SHALL become 0.
REQ-037 On reset, the active set SHALL become b0=B0_RST and b1=b2=a1=a2=0, and the shadow SHALL be given the same values.
REQ-038 On reset, pending, applied and err SHALL be 0, and wr_ready SHALL be 1 from the first cycle after reset.
REQ-039 Reset SHALL override all other inputs, including in mid-load or PEND; a committed but unapplied set SHALL be lost.

Verification
REQ-040 Reset then idle -> b0=16'sh4000, b1=b2=a1=a2=0, and wr_ready=1, pending=0.
REQ-041 Write addresses 0-4 with 0x1000, 0x2000, 0x1000, 0xC000, 0x0800, then commit, then sample_tick 3 cycles later -> pending=1 for 3 cycles, applied pulses once, and the outputs take the new values 1 cycle after the tick.
REQ-042 Write addresses 0-3 only, then commit -> err pulses, the state stays LOAD, and the outputs are unchanged.
REQ-043 Write to address 6 -> err pulses and the mask is unchanged; a write to address 4 plus commit in the same cycle (addresses 0-3 already written) -> the commit is accepted.
REQ-044 In PEND, abort and sample_tick in the same cycle -> the state goes to IDLE, applied=0, and the outputs are unchanged.
REQ-045 In PEND, assert reset -> the outputs return to their reset values and pending=0; a later sample_tick applies nothing.

Source files
------------

// File: rtl/iir_coef_loader.sv
// -----------------------------------------------------------------------------
// iir_coef_loader
//
// Double-buffered coefficient store for one biquad IIR stage. The host writes
// coefficients into a shadow set, commits the set once all five have been
// written, and the set is copied atomically into the active registers on the
// next filter sample boundary (sample_tick). The active registers alone drive
// the filter, so the stage never sees a half-updated set.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
// wr_ready depends only on registered state (low while a committed set waits
// for its tick), and the host holds wr_addr/wr_data stable while wr_valid is
// high.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   wr_valid     host offers a coefficient write
//   wr_ready     block can accept a write
//   wr_addr      0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 illegal
//   wr_data      coefficient value (signed DW)
//   commit       one-cycle request to apply the shadow set
//   abort        discard the pending load
//   sample_tick  one-cycle strobe at a filter sample boundary
//   b0..a2       active coefficients (registered)
//   pending      committed set waiting for sample_tick
//   applied      one-cycle pulse when the active set changes
//   err          one-cycle pulse on illegal address or illegal commit
//   fsm_state    debug view of the controller state (IDLE/LOAD/PEND)
// -----------------------------------------------------------------------------
module iir_coef_loader #(
    parameter int                     DW     = 16,
    parameter logic signed [DW-1:0]   B0_RST = 16'sh4000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [2:0]           wr_addr,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 commit,
    input  logic                 abort,
    input  logic                 sample_tick,
    output logic signed [DW-1:0] b0,
    output logic signed [DW-1:0] b1,
    output logic signed [DW-1:0] b2,
    output logic signed [DW-1:0] a1,
    output logic signed [DW-1:0] a2,
    output logic                 pending,
    output logic                 applied,
    output logic                 err,
    output logic [1:0]           fsm_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [4:0]           mask;
    logic [4:0]           mask_w;
    logic [4:0]           mask_next;
    logic [4:0]           wr_hit;
    logic signed [DW-1:0] shadow [5];

    logic wr_accept;
    logic addr_ok;
    logic commit_ok;
    logic commit_bad;
    logic tick_apply;
    logic err_next;

    assign fsm_state = state;

    always_comb begin
        wr_ready   = (state != ST_PEND);
        // abort wins over everything else in its cycle, including writes
        wr_accept  = wr_valid && wr_ready && !abort;
        addr_ok    = (wr_addr <= 3'd4);
        wr_hit     = (wr_accept && addr_ok) ? (5'b00001 << wr_addr) : 5'b00000;
        // commit is judged against the mask including this cycle's write
        mask_w     = mask | wr_hit;
        commit_ok  = commit && !abort && (state != ST_PEND) && (mask_w == 5'b11111);
        commit_bad = commit && !abort && (state != ST_PEND) && (mask_w != 5'b11111);
        // a tick in the commit cycle itself is not in PEND yet, so it is ignored
        tick_apply = sample_tick && !abort && (state == ST_PEND);
        err_next   = (wr_accept && !addr_ok) || commit_bad;

        mask_next  = mask_w;
        if (abort || tick_apply) begin
            mask_next = 5'b00000;
        end

        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else if (state == ST_PEND) begin
            state_next = tick_apply ? ST_IDLE : ST_PEND;
        end else if (commit_ok) begin
            state_next = ST_PEND;
        end else if (mask_w != 5'b00000) begin
            state_next = ST_LOAD;
        end else begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mask      <= 5'b00000;
            pending   <= 1'b0;
            applied   <= 1'b0;
            err       <= 1'b0;
            b0        <= B0_RST;
            b1        <= '0;
            b2        <= '0;
            a1        <= '0;
            a2        <= '0;
            shadow[0] <= B0_RST;
            shadow[1] <= '0;
            shadow[2] <= '0;
            shadow[3] <= '0;
            shadow[4] <= '0;
        end else begin
            state   <= state_next;
            mask    <= mask_next;
            pending <= (state_next == ST_PEND);
            applied <= tick_apply;
            err     <= err_next;
            for (int i = 0; i < 5; i++) begin
                if (wr_hit[i]) begin
                    shadow[i] <= wr_data;
                end
            end
            if (tick_apply) begin
                b0 <= shadow[0];
                b1 <= shadow[1];
                b2 <= shadow[2];
                a1 <= shadow[3];
                a2 <= shadow[4];
            end
        end
    end

endmodule

// File: tb/tb_iir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_iir_coef_loader
//
// Drives directed scenarios followed by random traffic into iir_coef_loader.
// A behavioural model (arrays + a mask + a pending flag) predicts, for every
// clock edge, the visible outputs; the prediction is queued and a separate
// monitor compares it with the DUT just after the edge.
// -----------------------------------------------------------------------------
module tb_iir_coef_loader;

  localparam int DW = 16;
  localparam int W  = 4 + 5 * DW;
  localparam logic signed [DW-1:0] B0_RST = 16'sh4000;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [2:0]           wr_addr = 3'd0;
  logic signed [DW-1:0] wr_data = '0;
  logic                 commit = 1'b0;
  logic                 abort = 1'b0;
  logic                 sample_tick = 1'b0;
  logic signed [DW-1:0] b0, b1, b2, a1, a2;
  logic                 pending, applied, err;
  logic [1:0]           fsm_state;

  always #5 clk = ~clk;

  iir_coef_loader #(.DW(DW), .B0_RST(B0_RST)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .abort(abort), .sample_tick(sample_tick),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .pending(pending), .applied(applied), .err(err),
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  logic signed [DW-1:0] m_active [5];
  logic signed [DW-1:0] m_shadow [5];
  logic [4:0]           m_mask;
  logic                 m_pend;
  logic                 m_applied;
  logic                 m_err;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  function automatic logic [W-1:0] model_snapshot();
    return {!m_pend, m_pend, m_applied, m_err,
            m_active[0], m_active[1], m_active[2], m_active[3], m_active[4]};
  endfunction

  task automatic model_edge(input logic wv, input logic [2:0] wa,
                            input logic signed [DW-1:0] wd,
                            input logic cm, input logic ab,
                            input logic tk, input logic rst);
    m_applied = 1'b0;
    m_err     = 1'b0;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_active[i] = (i == 0) ? B0_RST : '0;
        m_shadow[i] = m_active[i];
      end
      m_mask = 5'd0;
      m_pend = 1'b0;
    end else if (ab) begin
      m_mask = 5'd0;
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (tk) begin
        for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
        m_mask    = 5'd0;
        m_pend    = 1'b0;
        m_applied = 1'b1;
      end
    end else begin
      if (wv) begin
        if (int'(wa) < 5) begin
          m_shadow[wa] = wd;
          m_mask[wa]   = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (cm) begin
        if (m_mask == 5'b11111) m_pend = 1'b1;
        else                    m_err  = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic wv, input logic [2:0] wa,
                      input logic signed [DW-1:0] wd,
                      input logic cm, input logic ab,
                      input logic tk, input logic rst);
    @(negedge clk);
    wr_valid    = wv;
    wr_addr     = wa;
    wr_data     = wd;
    commit      = cm;
    abort       = ab;
    sample_tick = tk;
    reset       = rst;
    model_edge(wv, wa, wd, cm, ab, tk, rst);
    exp_q.push_back(model_snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, '0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [2:0] a, input logic signed [DW-1:0] d);
    step(1, a, d, 0, 0, 0, 0);
  endtask
  task automatic do_commit();
    step(0, 3'd0, '0, 1, 0, 0, 0);
  endtask
  task automatic do_tick();
    step(0, 3'd0, '0, 0, 0, 1, 0);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, '0, 0, 0, 0, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {wr_ready, pending, applied, err, b0, b1, b2, a1, a2};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_check t=%0t got rdy/pend/appl/err=%b coef=%h %h %h %h %h want rdy/pend/appl/err=%b coef=%h %h %h %h %h",
                 $time, act_v[W-1:W-4], act_v[79:64], act_v[63:48], act_v[47:32], act_v[31:16], act_v[15:0],
                 exp_v[W-1:W-4], exp_v[79:64], exp_v[63:48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic wv, cm, ab, tk, rst;
    logic [2:0] wa;
    logic signed [DW-1:0] wd;

    // reset then idle
    do_reset(2);
    idle(3);

    // full load, commit, tick three cycles later
    wr(3'd0, 16'sh1000);
    wr(3'd1, 16'sh2000);
    wr(3'd2, 16'sh1000);
    wr(3'd3, 16'shC000);
    wr(3'd4, 16'sh0800);
    do_commit();
    idle(2);
    do_tick();
    idle(2);

    // incomplete mask commit, commit in IDLE
    do_commit();
    wr(3'd0, 16'sh0111);
    wr(3'd1, 16'sh0222);
    wr(3'd2, 16'sh0333);
    wr(3'd3, 16'sh0444);
    do_commit();
    do_tick();
    // illegal address, then same-cycle last write plus commit
    wr(3'd6, 16'sh7777);
    do_commit();
    step(1, 3'd4, 16'sh0555, 1, 0, 1, 0);  // tick in commit cycle must not apply
    idle(1);
    do_tick();
    idle(1);

    // PEND: abort together with tick
    wr(3'd0, 16'sh1234); wr(3'd1, 16'sh2345); wr(3'd2, 16'sh3456);
    wr(3'd3, 16'sh4567); wr(3'd4, 16'sh5678);
    do_commit();
    step(0, 3'd0, '0, 0, 1, 1, 0);
    idle(1);
    do_tick();
    // rewrite same address, then reset while PEND
    wr(3'd0, 16'sh0101); wr(3'd0, 16'sh0202); wr(3'd1, 16'sh0303);
    wr(3'd2, 16'sh0404); wr(3'd3, 16'sh0505); wr(3'd4, 16'sh0606);
    do_commit();
    idle(1);
    do_reset(1);
    idle(1);
    do_tick();
    idle(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      ab  = ($urandom_range(0, 19) == 0);
      wv  = ab ? 1'b0 : ($urandom_range(0, 2) != 0);
      wa  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wd  = DW'($urandom);
      cm  = ($urandom_range(0, 5) == 0);
      tk  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(wv, wa, wd, cm, ab, tk, rst);
    end
    idle(1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
